mux_nxmx1_arb: RTL and testbench
================================

# mux_nxmx1_arb

Parametrised N-input, INPUT_LENGTH-wide arbitrated multiplexer with valid/ready handshake on every channel and a registered output stage. It selects one requesting channel per transfer, using either fixed priority or round-robin, and forwards that channel's data through a one-entry output buffer. It sits between multiple datapath producers (forwarding paths, writeback sources) and a single consumer. It is the sequential successor to the purely combinational Nx2x1/Nx4x1 mux trees.

## Interface
Parameters:
- INPUT_LENGTH, 64, data bits per channel
- INPUT_WIDTH, 4, number of channels (≥2)
- SELECT_WIDTH, $clog2(INPUT_WIDTH), grant index width

Ports:
- clk_i  input  1  clock, rising edge
- reset_ni  input  1  reset, asynchronous, active-low
- inputs_i  input  [INPUT_WIDTH][INPUT_LENGTH]  channel data
- valids_i  input  INPUT_WIDTH  per-channel valid
- readys_o  output  INPUT_WIDTH  per-channel ready (one-hot or zero)
- mode_i  input  1  0 = fixed priority (lowest index wins), 1 = round-robin
- outputs_o  output  INPUT_LENGTH  registered selected data
- valid_o  output  1  output buffer full
- ready_i  input  1  consumer accepts outputs_o
- grant_o  output  SELECT_WIDTH  index of the channel held in the output buffer
- lasts_i  input  INPUT_WIDTH  end-of-burst marker; present only with MUX_ARB_HOLD_EN

## Operation
- Output buffer states: EMPTY (valid_o=0) and FULL (valid_o=1).
- can_load = !valid_o | ready_i.
- Arbitration is combinational over valids_i each cycle, giving winner index w. The buffer loads when can_load and any valids_i is set.
- Fixed priority: w = lowest set index.
- Round-robin: w = first set index at or above pointer rr_q, wrapping modulo INPUT_WIDTH.
- readys_o[w] = can_load & valids_i[w]. All other bits are 0. A transfer on channel k means valids_i[k] & readys_o[k].
- On a channel transfer:
  - outputs_o ← inputs_i[w]
  - grant_o ← w
  - valid_o ← 1
  - rr_q ← (w+1) mod INPUT_WIDTH, with wrap at INPUT_WIDTH−1 → 0
- rr_q updates only on a transfer, in both modes. Mode_i affects only selection.
- Consumer accept with no new input: valid_o ← 0. outputs_o and grant_o hold their last values.
- Simultaneous consumer accept and new channel transfer: buffer stays FULL with the new data. Throughput is one beat per cycle.
- While FULL and ready_i=0: all readys_o=0, and outputs_o/grant_o are stable.
- A mode_i change takes effect in the same cycle's arbitration and does not disturb the buffer.

## Timing
- Latency: 1 cycle from channel transfer to valid_o/outputs_o.
- Reset (reset_ni=0, async, any cycle including mid-transfer):
  - outputs_o=0, valid_o=0, grant_o=0, rr_q=0, hold state IDLE
  - readys_o=0 while in reset
  - any pending buffer content is discarded
- readys_o depends combinationally on valids_i, ready_i and mode_i. There is no combinational path from inputs_i to outputs_o.

## Configuration
- MUX_ARB_HOLD_EN defined:
  - adds lasts_i and a two-state lock FSM, IDLE/LOCKED
  - a transfer with lasts_i[w]=0 moves the FSM to LOCKED on w
  - in LOCKED only channel w may be granted; other channels see readys_o=0 even when w is idle
  - a transfer on w with lasts_i[w]=1 returns the FSM to IDLE
  - rr_q advances only on that last beat
  - reset → IDLE
- MUX_ARB_HOLD_EN undefined: there is no lasts_i port and arbitration runs every beat.

## Test plan
- Reset mid-transfer: valid_o=1 holding 0xAA, then reset_ni=0 → outputs_o=0, valid_o=0, grant_o=0 immediately without a clock; after release, first round-robin grant goes to channel 0.
- Fixed priority, mode_i=0, valids_i=4'b1010, ready_i=1 → channel 1 transfers each cycle, outputs_o=inputs_i[1] one cycle later, channel 3 starves.
- Round-robin, mode_i=1, valids_i=4'b1111, ready_i=1 → grant_o sequence 0,1,2,3,0 on consecutive cycles with continuous valid_o.
- Backpressure: buffer FULL with 0x1234 from channel 2, ready_i=0 for 3 cycles → readys_o=0, outputs_o=0x1234 stable; with ready_i=1 and valids_i=4'b0001 → same-cycle reload, outputs_o=inputs_i[0] next cycle.
- Wrap-around: rr_q=3, valids_i=4'b0001 → grant 0, then rr_q=1.
- MUX_ARB_HOLD_EN: channel 2 sends 3 beats with lasts_i[2] asserted on beat 3 while channel 0 is valid throughout → grant_o=2,2,2 then 0; channel 0 readys_o stays 0 during the burst.

Source files
------------

// File: rtl/mux_nxmx1_arb.sv
// mux_nxmx1_arb: N-channel arbitrated multiplexer with a one-entry registered
// output buffer and valid/ready handshakes on every channel and on the output.
//
// Optional feature macro: MUX_ARB_HOLD_EN
//   When defined, adds lasts_i and an IDLE/LOCKED burst-lock FSM that keeps the
//   grant on one channel until that channel's last beat transfers.
//
// Parameters:
//   INPUT_LENGTH  data bits per channel
//   INPUT_WIDTH   number of channels (>= 2)
//   SELECT_WIDTH  grant index width
//
// Ports:
//   clk_i      rising-edge clock
//   reset_ni   asynchronous active-low reset
//   inputs_i   per-channel data
//   valids_i   per-channel valid
//   readys_o   per-channel ready (one-hot or zero, combinational)
//   mode_i     0 = fixed priority (lowest index), 1 = round-robin
//   lasts_i    per-channel end-of-burst marker (MUX_ARB_HOLD_EN only)
//   outputs_o  registered selected data
//   valid_o    output buffer full
//   ready_i    consumer accepts outputs_o
//   grant_o    index of the channel held in the output buffer
module mux_nxmx1_arb #(
    parameter int unsigned INPUT_LENGTH = 64,
    parameter int unsigned INPUT_WIDTH  = 4,
    parameter int unsigned SELECT_WIDTH = $clog2(INPUT_WIDTH)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_ni,
    input  logic [INPUT_WIDTH-1:0][INPUT_LENGTH-1:0] inputs_i,
    input  logic [INPUT_WIDTH-1:0]                   valids_i,
    output logic [INPUT_WIDTH-1:0]                   readys_o,
    input  logic                                     mode_i,
`ifdef MUX_ARB_HOLD_EN
    input  logic [INPUT_WIDTH-1:0]                   lasts_i,
`endif
    output logic [INPUT_LENGTH-1:0]                  outputs_o,
    output logic                                     valid_o,
    input  logic                                     ready_i,
    output logic [SELECT_WIDTH-1:0]                  grant_o
);

    localparam logic [SELECT_WIDTH-1:0] LAST_IDX = SELECT_WIDTH'(INPUT_WIDTH - 1);

    logic [INPUT_LENGTH-1:0] data_q;
    logic                    valid_q;
    logic [SELECT_WIDTH-1:0] grant_q;
    logic [SELECT_WIDTH-1:0] rr_q;

    logic [INPUT_WIDTH-1:0]  req_c;
    logic [INPUT_WIDTH-1:0]  readys_c;
    logic [SELECT_WIDTH-1:0] win_c;
    logic [SELECT_WIDTH-1:0] rr_next_c;
    logic                    any_c;
    logic                    can_load_c;
    logic                    xfer_c;
    int unsigned             idx;

`ifdef MUX_ARB_HOLD_EN
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } hold_state_e;

    hold_state_e             state_q;
    logic [SELECT_WIDTH-1:0] lock_q;

    // While locked, only the owning channel may compete.
    always_comb begin
        req_c = valids_i;
        if (state_q == LOCKED) begin
            req_c         = '0;
            req_c[lock_q] = valids_i[lock_q];
        end
    end
`else
    assign req_c = valids_i;
`endif

    // Winner selection: lowest set index, or first set index at/after rr_q.
    always_comb begin
        win_c = '0;
        any_c = 1'b0;
        idx   = 0;
        if (!mode_i) begin
            for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
                if (!any_c && req_c[SELECT_WIDTH'(i)]) begin
                    any_c = 1'b1;
                    win_c = SELECT_WIDTH'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
                idx = 32'(rr_q) + i;
                if (idx >= INPUT_WIDTH) begin
                    idx = idx - INPUT_WIDTH;
                end
                if (!any_c && req_c[SELECT_WIDTH'(idx)]) begin
                    any_c = 1'b1;
                    win_c = SELECT_WIDTH'(idx);
                end
            end
        end
    end

    assign can_load_c = !valid_q || ready_i;
    assign xfer_c     = can_load_c && any_c;
    assign rr_next_c  = (win_c == LAST_IDX) ? '0 : win_c + SELECT_WIDTH'(1);

    // One-hot ready toward the winning channel; forced low during reset.
    always_comb begin
        readys_c = '0;
        if (xfer_c) begin
            readys_c[win_c] = 1'b1;
        end
    end

    assign readys_o = reset_ni ? readys_c : '0;

    // Output buffer, round-robin pointer and burst-lock state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            rr_q    <= '0;
`ifdef MUX_ARB_HOLD_EN
            state_q <= IDLE;
            lock_q  <= '0;
`endif
        end else begin
            if (xfer_c) begin
                data_q  <= inputs_i[win_c];
                grant_q <= win_c;
                valid_q <= 1'b1;
`ifdef MUX_ARB_HOLD_EN
                if (lasts_i[win_c]) begin
                    state_q <= IDLE;
                    rr_q    <= rr_next_c;
                end else begin
                    state_q <= LOCKED;
                    lock_q  <= win_c;
                end
`else
                rr_q    <= rr_next_c;
`endif
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign outputs_o = data_q;
    assign valid_o   = valid_q;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_mux_nxmx1_arb.sv
module tb_mux_nxmx1_arb;

    localparam int unsigned L = 64;
    localparam int unsigned N = 4;
    localparam int unsigned S = 2;

    logic                  clk;
    logic                  reset_ni;
    logic [N-1:0][L-1:0]   inputs;
    logic [N-1:0]          valids;
    logic [N-1:0]          readys;
    logic                  mode;
    logic [L-1:0]          outputs;
    logic                  valid_o;
    logic                  ready_i;
    logic [S-1:0]          grant;
`ifdef MUX_ARB_HOLD_EN
    logic [N-1:0]          lasts;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    mux_nxmx1_arb #(.INPUT_LENGTH(L), .INPUT_WIDTH(N), .SELECT_WIDTH(S)) dut (
        .clk_i     (clk),
        .reset_ni  (reset_ni),
        .inputs_i  (inputs),
        .valids_i  (valids),
        .readys_o  (readys),
        .mode_i    (mode),
`ifdef MUX_ARB_HOLD_EN
        .lasts_i   (lasts),
`endif
        .outputs_o (outputs),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .grant_o   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: buffer contents, rr pointer, burst lock.
    logic [L-1:0] m_data;
    bit           m_valid;
    int           m_grant;
    int           m_rr;
    bit           m_locked;
    int           m_lock;

    always @(negedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            m_data = '0; m_valid = 0; m_grant = 0; m_rr = 0; m_locked = 0; m_lock = 0;
            if (chk_en && !clk) begin
                check("rst_readys", 64'(readys), 64'd0);
                check("rst_valid", 64'(valid_o), 64'd0);
                check("rst_data", 64'(outputs), 64'd0);
            end
        end else if (chk_en) begin
            bit           can;
            bit           found;
            int           w;
            logic [N-1:0] exp_readys;
            can   = !m_valid || ready_i;
            found = 0;
            w     = 0;
            for (int k = 0; k < int'(N); k++) begin
                int c;
                c = mode ? (m_rr + k) % int'(N) : k;
                if (!found && valids[c] && (!m_locked || c == m_lock)) begin
                    found = 1;
                    w     = c;
                end
            end
            exp_readys = '0;
            if (can && found) exp_readys[w] = 1'b1;
            check("m_readys", 64'(readys), 64'(exp_readys));
            check("m_valid", 64'(valid_o), 64'(m_valid));
            check("m_data", 64'(outputs), 64'(m_data));
            check("m_grant", 64'(grant), 64'(m_grant));
            if (can && found) begin
                m_data  = inputs[w];
                m_grant = w;
                m_valid = 1;
`ifdef MUX_ARB_HOLD_EN
                if (lasts[w]) begin
                    m_locked = 0;
                    m_rr     = (w + 1) % int'(N);
                end else begin
                    m_locked = 1;
                    m_lock   = w;
                end
`else
                m_rr = (w + 1) % int'(N);
`endif
            end else if (ready_i) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ni = 1'b0;
        inputs   = '0;
        valids   = '0;
        mode     = 1'b0;
        ready_i  = 1'b1;
`ifdef MUX_ARB_HOLD_EN
        lasts    = '1;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset_ni = 1'b1;
        chk_en   = 1;
        check("init_valid", 64'(valid_o), 64'd0);
        check("init_grant", 64'(grant), 64'd0);

        // Fill buffer with 0xAA from channel 1, hold it, then async reset.
        inputs[0] = 64'h0000_0000_0000_00C0;
        inputs[1] = 64'h0000_0000_0000_00AA;
        inputs[2] = 64'h0000_0000_0000_00C2;
        inputs[3] = 64'h0000_0000_0000_00C3;
        valids  = 4'b0010;
        ready_i = 1'b0;
        step();
        valids = 4'b0000;
        check("aa_valid", 64'(valid_o), 64'd1);
        check("aa_data", 64'(outputs), 64'hAA);
        check("aa_grant", 64'(grant), 64'd1);
        #2;
        valids   = 4'b1111;
        reset_ni = 1'b0;
        #1;
        check("async_data", 64'(outputs), 64'd0);
        check("async_valid", 64'(valid_o), 64'd0);
        check("async_grant", 64'(grant), 64'd0);
        check("async_readys", 64'(readys), 64'd0);
        step();
        reset_ni = 1'b1;
        mode     = 1'b1;
        ready_i  = 1'b1;

        // Round-robin over all-valid: 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_grant", 64'(grant), 64'(i % 4));
            check("rr_valid", 64'(valid_o), 64'd1);
        end
        check("rr_data", 64'(outputs), 64'h00C0);

        // Fixed priority 1010: channel 1 every cycle.
        mode      = 1'b0;
        valids    = 4'b1010;
        inputs[1] = 64'h1111_2222_3333_4444;
        inputs[3] = 64'h3333_3333_3333_3333;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fp_grant", 64'(grant), 64'd1);
            check("fp_data", 64'(outputs), 64'h1111_2222_3333_4444);
            check("fp_readys", 64'(readys), 64'b0010);
        end

        // Backpressure with 0x1234 from channel 2.
        valids    = 4'b0100;
        inputs[2] = 64'h1234;
        step();
        ready_i = 1'b0;
        valids  = 4'b0001;
        inputs[0] = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_readys", 64'(readys), 64'd0);
            step();
            check("bp_data", 64'(outputs), 64'h1234);
            check("bp_grant", 64'(grant), 64'd2);
        end
        ready_i = 1'b1;
        #1;
        check("reload_readys", 64'(readys), 64'b0001);
        step();
        check("reload_data", 64'(outputs), 64'hDEAD_BEEF_0000_0001);
        check("reload_grant", 64'(grant), 64'd0);

        // Wrap-around: transfer on 2 leaves rr=3; 0101 in RR grants 0, rr=1.
        valids = 4'b0100;
        step();
        mode   = 1'b1;
        valids = 4'b0101;
        #1;
        check("wrap_readys", 64'(readys), 64'b0001);
        step();
        check("wrap_grant", 64'(grant), 64'd0);
        valids = 4'b0011;
        #1;
        check("rr1_readys", 64'(readys), 64'b0010);
        step();
        check("rr1_grant", 64'(grant), 64'd1);

        // Mode flip while full and stalled leaves buffer untouched.
        ready_i = 1'b0;
        valids  = 4'b1000;
        step();
        mode = 1'b0;
        step();
        check("flip_grant", 64'(grant), 64'd1);
        ready_i = 1'b1;

        // Drain: valid drops, data and grant hold.
        valids = 4'b0000;
        step();
        check("drain_valid", 64'(valid_o), 64'd0);
        check("drain_data", 64'(outputs), 64'h1111_2222_3333_4444);
        check("drain_grant", 64'(grant), 64'd1);

`ifdef MUX_ARB_HOLD_EN
        // Burst of 3 on channel 2 while channel 0 is valid.
        mode   = 1'b0;
        lasts  = 4'b0000;
        valids = 4'b0100;
        step();
        check("hold_b1", 64'(grant), 64'd2);
        valids = 4'b0101;
        #1;
        check("hold_r0", 64'(readys), 64'b0100);
        step();
        check("hold_b2", 64'(grant), 64'd2);
        valids = 4'b0001;
        #1;
        check("hold_idle_lock", 64'(readys), 64'd0);
        step();
        valids = 4'b0101;
        lasts  = 4'b0100;
        step();
        check("hold_b3", 64'(grant), 64'd2);
        lasts = 4'b1111;
        #1;
        check("hold_rel", 64'(readys), 64'b0001);
        step();
        check("hold_next", 64'(grant), 64'd0);
        valids = 4'b0000;
        step();
`endif

        step();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
